dmem_port_arbiter: RTL and testbench

Sequencer and arbiter for the single data-memory port. Shares the port between the pipeline MEM stage and a debug/loader requester. Inserts a configurable number of wait states per access. Stalls the pipeline until the CPU access completes. Sits between the EX_MEM outputs and the data memory; its stall output feeds the pipeline-register and PC load enables.

---
 rtl/dmem_arb_pkg.sv | 20 ++
 rtl/dmem_wait_counter.sv | 32 +++
 rtl/dmem_port_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and RAM_CTRL field positions for the data-memory port arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic {
    CPU = 1'b0,
    DBG = 1'b1
  } owner_e;

  localparam int SIZE_HI = 3;
  localparam int SIZE_LO = 2;
  localparam int RW      = 1;
  localparam int E       = 0;

endpackage

// File: rtl/dmem_wait_counter.sv
// 4-bit loadable down-counter that times the wait states of one memory access.
module dmem_wait_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == 4'd0);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single data-memory port between the MEM stage and a debug/loader
// requester, with WAIT_CYCLES extra cycles per access. Round-robin when DMEM_ARB_FAIR_EN.
//
// Handshakes: the CPU holds cpu_ram_ctrl[E] and its fields while cpu_stall is high;
// the access completes in the cycle cpu_stall drops. The debug side holds dbg_req and
// its fields until dbg_done (one-cycle pulse) and drops dbg_req on the following cycle.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        cpu_ram_ctrl,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_rw,
  input  logic [1:0]        dbg_size,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_done,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_di,
  input  logic [DATA_W-1:0] mem_do,
  output logic [1:0]        mem_size,
  output logic              mem_rw,
  output logic              mem_e,
  output state_e            fsm_state
);

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        size_q, size_d;
  logic              rw_q, rw_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;

  logic cpu_req;
  logic grant_dbg;
  logic cnt_load, cnt_dec, cnt_zero;

  assign cpu_req = cpu_ram_ctrl[E];

`ifdef DMEM_ARB_FAIR_EN
  owner_e last_owner_q, last_owner_d;

  // On contention the requester that did not win the previous grant goes first.
  assign grant_dbg = dbg_req && (!cpu_req || (last_owner_q == CPU));

  always_comb begin
    last_owner_d = last_owner_q;
    if ((state_q == IDLE) && (cpu_req || dbg_req)) begin
      last_owner_d = grant_dbg ? DBG : CPU;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_owner_q <= DBG;
    end else begin
      last_owner_q <= last_owner_d;
    end
  end
`else
  assign grant_dbg = dbg_req && !cpu_req;
`endif

  dmem_wait_counter u_wait_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (WAIT_LD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    size_d      = size_q;
    rw_d        = rw_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;

    case (state_q)
      IDLE: begin
        if (cpu_req || dbg_req) begin
          state_d  = ACCESS;
          cnt_load = 1'b1;
          if (grant_dbg) begin
            owner_d = DBG;
            addr_d  = dbg_addr;
            wdata_d = dbg_wdata;
            size_d  = dbg_size;
            rw_d    = dbg_rw;
          end else begin
            owner_d = CPU;
            addr_d  = cpu_addr;
            wdata_d = cpu_wdata;
            size_d  = cpu_ram_ctrl[SIZE_HI:SIZE_LO];
            rw_d    = cpu_ram_ctrl[RW];
          end
        end
      end
      ACCESS: begin
        if (cnt_zero) begin
          state_d = RESP;
          // Captured even if the CPU has since dropped its request.
          if (!rw_q) begin
            if (owner_q == DBG) begin
              dbg_rdata_d = mem_do;
            end else begin
              cpu_rdata_d = mem_do;
            end
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      owner_q     <= CPU;
      addr_q      <= '0;
      wdata_q     <= '0;
      size_q      <= 2'b00;
      rw_q        <= 1'b0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      size_q      <= size_d;
      rw_q        <= rw_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  always_comb begin
    mem_e    = 1'b0;
    mem_rw   = 1'b0;
    mem_size = 2'b00;
    mem_a    = '0;
    mem_di   = '0;
    if (state_q == ACCESS) begin
      mem_e    = 1'b1;
      mem_rw   = rw_q;
      mem_size = size_q;
      mem_a    = addr_q;
      mem_di   = wdata_q;
    end
  end

  assign cpu_stall = cpu_req && !((state_q == RESP) && (owner_q == CPU));
  assign dbg_done  = (state_q == RESP) && (owner_q == DBG);
  assign cpu_rdata = cpu_rdata_q;
  assign dbg_rdata = dbg_rdata_q;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Randomized scoreboard bench for dmem_port_arbiter, plus a WAIT_CYCLES=0 instance.
// Build with +define+DMEM_ARB_FAIR_EN to exercise the round-robin variant.
module tb_dmem_port_arbiter;
  import dmem_arb_pkg::*;

  localparam int W  = 2;
  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk;
  logic          reset;
  logic [3:0]    cpu_ram_ctrl;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;
  logic          dbg_req;
  logic          dbg_rw;
  logic [1:0]    dbg_size;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic [DW-1:0] dbg_rdata;
  logic          dbg_done;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_di;
  logic [DW-1:0] mem_do;
  logic [1:0]    mem_size;
  logic          mem_rw;
  logic          mem_e;
  state_e        fsm_state;

  // second instance with zero wait states
  logic [3:0]    c0_ctrl;
  logic [AW-1:0] c0_addr;
  logic [DW-1:0] c0_rdata;
  logic          c0_stall;
  logic [DW-1:0] d0_rdata;
  logic          d0_done;
  logic [AW-1:0] mem0_a;
  logic [DW-1:0] mem0_di;
  logic [DW-1:0] mem0_do;
  logic [1:0]    mem0_size;
  logic          mem0_rw;
  logic          mem0_e;
  state_e        fsm0_state;

  int checks = 0;
  int fails  = 0;

  logic [DW-1:0] ram     [0:255];
  logic [DW-1:0] ref_mem [0:255];

  // expected queues: memory port {addr, rw, size, wdata}; responses {check_data, data}
  logic [AW+1+2+DW-1:0] exp_mem_q[$];
  logic [DW:0]          exp_cpu_q[$];
  logic [DW:0]          exp_dbg_q[$];

  bit last_dbg = 1'b1;

  dmem_port_arbiter #(.WAIT_CYCLES(W), .ADDR_W(AW), .DATA_W(DW)) u_dut (
    .clk(clk), .reset(reset),
    .cpu_ram_ctrl(cpu_ram_ctrl), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_rw(dbg_rw), .dbg_size(dbg_size), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata), .dbg_done(dbg_done),
    .mem_a(mem_a), .mem_di(mem_di), .mem_do(mem_do), .mem_size(mem_size),
    .mem_rw(mem_rw), .mem_e(mem_e), .fsm_state(fsm_state)
  );

  dmem_port_arbiter #(.WAIT_CYCLES(0), .ADDR_W(AW), .DATA_W(DW)) u_dut0 (
    .clk(clk), .reset(reset),
    .cpu_ram_ctrl(c0_ctrl), .cpu_addr(c0_addr), .cpu_wdata(32'h0),
    .cpu_rdata(c0_rdata), .cpu_stall(c0_stall),
    .dbg_req(1'b0), .dbg_rw(1'b0), .dbg_size(2'b00), .dbg_addr(8'h00),
    .dbg_wdata(32'h0), .dbg_rdata(d0_rdata), .dbg_done(d0_done),
    .mem_a(mem0_a), .mem_di(mem0_di), .mem_do(mem0_do), .mem_size(mem0_size),
    .mem_rw(mem0_rw), .mem_e(mem0_e), .fsm_state(fsm0_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  // data memory device models
  assign mem_do  = ram[mem_a];
  assign mem0_do = {24'hA5A5A5, mem0_a};

  always @(posedge clk) begin
    if (mem_e && mem_rw) ram[mem_a] = mem_di;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // driver tasks: called just after a rising edge, return just after a rising edge
  task automatic cpu_txn(input bit rw, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [1:0] sz, input int exp_cyc);
    int n;
    n = 0;
    cpu_ram_ctrl = {sz, rw, 1'b1};
    cpu_addr     = a;
    cpu_wdata    = d;
    @(negedge clk);
    while (cpu_stall && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("cpu_stall_len", 64'(n), 64'(exp_cyc));
    @(posedge clk);
    #1;
    cpu_ram_ctrl = 4'h0;
    cpu_addr     = '0;
    cpu_wdata    = '0;
  endtask

  task automatic dbg_txn(input bit rw, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [1:0] sz, input int exp_cyc);
    int n;
    n = 0;
    dbg_req   = 1'b1;
    dbg_rw    = rw;
    dbg_addr  = a;
    dbg_wdata = d;
    dbg_size  = sz;
    @(negedge clk);
    while (!dbg_done && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("dbg_done_latency", 64'(n), 64'(exp_cyc));
    @(posedge clk);
    #1;
    dbg_req   = 1'b0;
    dbg_rw    = 1'b0;
    dbg_addr  = '0;
    dbg_wdata = '0;
    dbg_size  = 2'b00;
  endtask

  // Transaction-level model: decide grant order, queue expectations, then drive.
  // kind: 0 = CPU only, 1 = debug only, 2 = both in the same cycle.
  task automatic round(input int kind,
                       input bit c_rw, input logic [AW-1:0] c_a, input logic [DW-1:0] c_d,
                       input bit d_rw, input logic [AW-1:0] d_a, input logic [DW-1:0] d_d);
    logic [1:0] c_sz, d_sz;
    bit has_c, has_d, cpu_first;
    int c_cyc, d_cyc;
    c_sz  = 2'($urandom_range(0, 3));
    d_sz  = 2'($urandom_range(0, 3));
    has_c = (kind != 1);
    has_d = (kind != 0);
    if (has_c && has_d) begin
`ifdef DMEM_ARB_FAIR_EN
      cpu_first = last_dbg;
`else
      cpu_first = 1'b1;
`endif
    end else begin
      cpu_first = has_c;
    end
    if (has_c && cpu_first) exp_mem_q.push_back({c_a, c_rw, c_sz, c_d});
    if (has_d)              exp_mem_q.push_back({d_a, d_rw, d_sz, d_d});
    if (has_c && !cpu_first) exp_mem_q.push_back({c_a, c_rw, c_sz, c_d});
    last_dbg = (has_c && has_d) ? cpu_first : has_d;
    c_cyc = (cpu_first || !has_d) ? W + 2 : 2 * W + 5;
    d_cyc = (!cpu_first || !has_c) ? W + 2 : 2 * W + 5;
    if (has_c) begin
      if (c_rw) begin
        ref_mem[c_a] = c_d;
        exp_cpu_q.push_back({1'b0, 32'h0});
      end else begin
        exp_cpu_q.push_back({1'b1, ref_mem[c_a]});
      end
    end
    if (has_d) begin
      if (d_rw) begin
        ref_mem[d_a] = d_d;
        exp_dbg_q.push_back({1'b0, 32'h0});
      end else begin
        exp_dbg_q.push_back({1'b1, ref_mem[d_a]});
      end
    end
    if (has_c && has_d) begin
      fork
        cpu_txn(c_rw, c_a, c_d, c_sz, c_cyc);
        dbg_txn(d_rw, d_a, d_d, d_sz, d_cyc);
      join
    end else if (has_c) begin
      cpu_txn(c_rw, c_a, c_d, c_sz, c_cyc);
    end else begin
      dbg_txn(d_rw, d_a, d_d, d_sz, d_cyc);
    end
  endtask

  // scoreboard monitor
  bit mem_e_prev = 1'b0;
  int acc_len    = -1000;

  always @(negedge clk) begin
    logic [DW:0]          e;
    logic [AW+1+2+DW-1:0] m;
    if (!reset) begin
      acc_len = -1000;
    end else begin
      if (cpu_ram_ctrl[0] && !cpu_stall) begin
        if (exp_cpu_q.size() == 0) begin
          check("cpu_unexpected_done", 64'd1, 64'd0);
        end else begin
          e = exp_cpu_q.pop_front();
          if (e[DW]) check("cpu_rdata", 64'(cpu_rdata), 64'(e[DW-1:0]));
        end
      end
      if (dbg_done) begin
        if (exp_dbg_q.size() == 0) begin
          check("dbg_unexpected_done", 64'd1, 64'd0);
        end else begin
          e = exp_dbg_q.pop_front();
          if (e[DW]) check("dbg_rdata", 64'(dbg_rdata), 64'(e[DW-1:0]));
        end
      end
      if (mem_e && !mem_e_prev) begin
        if (exp_mem_q.size() == 0) begin
          check("mem_unexpected_access", 64'd1, 64'd0);
        end else begin
          m = exp_mem_q.pop_front();
          check("mem_port_fields", 64'({mem_a, mem_rw, mem_size, mem_di}), 64'(m));
        end
        acc_len = 0;
      end
      if (mem_e) acc_len++;
      if (!mem_e && mem_e_prev && acc_len >= 0) check("mem_e_len", 64'(acc_len), 64'(W + 1));
      if (!mem_e) check("mem_idle_zero", 64'({mem_a, mem_rw, mem_size, mem_di}), 64'd0);
    end
    mem_e_prev = mem_e;
  end

  initial begin
    int n, st, me;
    for (int i = 0; i < 256; i++) begin
      ram[i]     = $urandom;
      ref_mem[i] = ram[i];
    end
    ram[8'h10]     = 32'hDEADBEEF;
    ref_mem[8'h10] = 32'hDEADBEEF;
    reset        = 1'b0;
    cpu_ram_ctrl = 4'h0;
    cpu_addr     = '0;
    cpu_wdata    = '0;
    dbg_req      = 1'b0;
    dbg_rw       = 1'b0;
    dbg_size     = 2'b00;
    dbg_addr     = '0;
    dbg_wdata    = '0;
    c0_ctrl      = 4'h0;
    c0_addr      = '0;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_state", 64'(fsm_state), 64'(IDLE));
    check("rst_cpu_rdata", 64'(cpu_rdata), 64'd0);
    check("rst_dbg_rdata", 64'(dbg_rdata), 64'd0);
    check("rst_dbg_done", 64'(dbg_done), 64'd0);
    check("rst_mem", 64'({mem_e, mem_a, mem_rw, mem_size, mem_di}), 64'd0);
    cpu_ram_ctrl = 4'b0001;
    @(negedge clk);
    check("rst_stall_follows_e1", 64'(cpu_stall), 64'd1);
    check("rst_state_held", 64'(fsm_state), 64'(IDLE));
    cpu_ram_ctrl = 4'b0000;
    @(negedge clk);
    check("rst_stall_follows_e0", 64'(cpu_stall), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // zero wait states: stall 2 cycles, one ACCESS cycle
    c0_ctrl = {2'b10, 1'b0, 1'b1};
    c0_addr = 8'h33;
    st = 0;
    me = 0;
    n  = 0;
    @(negedge clk);
    while (c0_stall && n < 50) begin
      st++;
      if (mem0_e) me++;
      n++;
      @(negedge clk);
    end
    check("w0_stall_len", 64'(st), 64'd2);
    check("w0_access_len", 64'(me), 64'd1);
    check("w0_cpu_rdata", 64'(c0_rdata), 64'h00000000A5A5A533);
    @(posedge clk);
    #1;
    c0_ctrl = 4'h0;
    c0_addr = '0;

    // directed: CPU word read, debug write, contention after a CPU grant
    round(0, 1'b0, 8'h10, 32'h0, 1'b0, 8'h00, 32'h0);
    round(1, 1'b0, 8'h00, 32'h0, 1'b1, 8'h20, 32'h12345678);
    round(0, 1'b0, 8'h20, 32'h0, 1'b0, 8'h00, 32'h0);
    round(2, 1'b0, 8'h11, 32'h0, 1'b0, 8'h91, 32'h0);

    // CPU drops its write request mid-ACCESS: write must still commit
    cpu_ram_ctrl = {2'b10, 1'b1, 1'b1};
    cpu_addr     = 8'h44;
    cpu_wdata    = 32'hCAFEF00D;
    exp_mem_q.push_back({8'h44, 1'b1, 2'b10, 32'hCAFEF00D});
    ref_mem[8'h44] = 32'hCAFEF00D;
    last_dbg = 1'b0;
    @(posedge clk);
    #1;
    cpu_ram_ctrl = 4'h0;
    cpu_addr     = '0;
    cpu_wdata    = '0;
    n  = 0;
    me = 0;
    @(negedge clk);
    while (fsm_state != IDLE && n < 50) begin
      if (mem_e && mem_rw) me++;
      n++;
      @(negedge clk);
    end
    check("bubble_write_len", 64'(me), 64'(W + 1));
    @(posedge clk);
    #1;
    round(0, 1'b0, 8'h44, 32'h0, 1'b0, 8'h00, 32'h0);

    // randomized traffic; CPU and debug use disjoint address halves
    for (int r = 0; r < 40; r++) begin
      round(int'($urandom_range(0, 2)),
            1'($urandom_range(0, 1)), 8'($urandom_range(0, 127)), $urandom,
            1'($urandom_range(0, 1)), 8'($urandom_range(128, 255)), $urandom);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    // reset mid-ACCESS: abandoned, no dbg_done, rdata cleared
    @(posedge clk);
    #1;
    dbg_req  = 1'b1;
    dbg_rw   = 1'b0;
    dbg_addr = 8'h90;
    dbg_size = 2'b10;
    exp_mem_q.push_back({8'h90, 1'b0, 2'b10, 32'h0});
    repeat (2) @(posedge clk);
    #1;
    reset   = 1'b0;
    dbg_req = 1'b0;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_mid_state", 64'(fsm_state), 64'(IDLE));
      check("rst_mid_mem_e", 64'(mem_e), 64'd0);
      check("rst_mid_dbg_done", 64'(dbg_done), 64'd0);
      check("rst_mid_rdata", 64'({cpu_rdata, dbg_rdata}), 64'd0);
    end
    @(posedge clk);
    #1;
    reset    = 1'b1;
    last_dbg = 1'b1;
    dbg_addr = '0;
    dbg_size = 2'b00;

    for (int r = 0; r < 8; r++) begin
      round(int'($urandom_range(0, 2)),
            1'($urandom_range(0, 1)), 8'($urandom_range(0, 127)), $urandom,
            1'($urandom_range(0, 1)), 8'($urandom_range(128, 255)), $urandom);
    end

    repeat (3) @(negedge clk);
    check("cpu_q_drained", 64'(exp_cpu_q.size()), 64'd0);
    check("dbg_q_drained", 64'(exp_dbg_q.size()), 64'd0);
    check("mem_q_drained", 64'(exp_mem_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
